// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for the 8x8 register bank: two requesters, one write
// per cycle, r0 filtering, hold support and a debug write counter.
module regbank_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter bit FAIR   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              busy,
  output logic [7:0]        wr_count
);

  logic              r_last;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_zero;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // the ack mask stops a requester being granted twice while it drops req
  assign w_elig0 = req0 & ~ack0;
  assign w_elig1 = req1 & ~ack1;
  assign busy    = w_elig0 | w_elig1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (1'b1)
      (~hold & w_elig0 & w_elig1): begin
        if (FAIR && !r_last) w_gnt1 = 1'b1;
        else                 w_gnt0 = 1'b1;
      end
      (~hold & w_elig0 & ~w_elig1): w_gnt0 = 1'b1;
      (~hold & ~w_elig0 & w_elig1): w_gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign w_any  = w_gnt0 | w_gnt1;
  assign w_addr = w_gnt1 ? addr1 : addr0;
  assign w_data = w_gnt1 ? data1 : data0;
  assign w_zero = (w_addr == '0);
  assign w_wr   = w_any & ~w_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      wr_count <= 8'd0;
      r_last   <= 1'b1;
    end else begin
      ack0 <= w_gnt0;
      ack1 <= w_gnt1;
      err  <= w_any & w_zero;
      we3  <= w_wr;
      wa3  <= w_wr ? w_addr : '0;
      wd3  <= w_wr ? w_data : '0;
      if (w_wr) wr_count <= wr_count + 8'd1;
      if (w_any) r_last <= w_gnt1;
    end
  end

endmodule
